// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction-fetch initiator for the vcpu1 core.
//
// Owns the program counter, presents it to a combinational big-endian
// instruction ROM and captures the returned word into the IF/ID register.
// Handles stall, branch redirect, halt and a programmable post-reset delay.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   rom_en          out  ROM enable (high only while fetching)
//   rom_addr        out  word-aligned byte address to ROM (= pc)
//   rom_instruction in   ROM data, valid in the same cycle as rom_addr
//   stall           in   downstream hold request
//   redirect        in   branch/jump taken
//   redirect_pc     in   branch/jump target byte address
//   halt            in   stop fetching
//   id_valid        out  IF/ID holds a real instruction
//   id_pc           out  address of id_instr
//   id_instr        out  fetched instruction, 0 (NOP) when id_valid = 0
//   misalign_err    out  sticky: a redirect target was not word-aligned
//   dbg_state       out  current FSM state (0 WAIT, 1 FETCH, 2 HALTED)
//
// Control semantics: stall, redirect and halt are level inputs sampled on
// every rising edge; there is no valid/ready handshake. A fetched word is
// accepted on the edge ending the cycle in which rom_addr presented it.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(START_DELAY - 1);

  state_t      r_state,  w_state_nxt;
  logic [31:0] r_pc,     w_pc_nxt;
  logic [3:0]  r_cnt,    w_cnt_nxt;
  logic        r_valid,  w_valid_nxt;
  logic [31:0] r_id_pc,  w_id_pc_nxt;
  logic [31:0] r_instr,  w_instr_nxt;
  logic        r_err,    w_err_nxt;

  logic [31:0] w_target;
  logic        w_target_bad;

  assign w_target     = {redirect_pc[31:2], 2'b00};
  assign w_target_bad = |redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_pc    <= RESET_PC;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_id_pc <= 32'h0;
      r_instr <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_id_pc <= w_id_pc_nxt;
      r_instr <= w_instr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_id_pc_nxt = r_id_pc;
    w_instr_nxt = r_instr;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 4'd1;
        // A redirect here only retargets the first fetch; the delay still runs out.
        if (redirect) begin
          w_pc_nxt  = w_target;
          w_err_nxt = r_err | w_target_bad;
        end
        if (halt)                    w_state_nxt = S_HALTED;
        else if (r_cnt == LAST_WAIT) w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          // Squash whatever sits in IF/ID; this produces the one-cycle bubble.
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
          w_instr_nxt = 32'h0;
          w_err_nxt   = r_err | w_target_bad;
        end else if (halt) begin
          w_state_nxt = S_HALTED;
          w_valid_nxt = 1'b0;
          w_instr_nxt = 32'h0;
        end else if (!stall) begin
          w_instr_nxt = rom_instruction;
          w_id_pc_nxt = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;   // wraps modulo 2^32
        end
      end

      S_HALTED: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_err_nxt   = r_err | w_target_bad;
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_WAIT;
    endcase
  end

  assign rom_en       = (r_state == S_FETCH);
  assign rom_addr     = r_pc;
  assign id_valid     = r_valid;
  assign id_pc        = r_id_pc;
  assign id_instr     = r_valid ? r_instr : 32'h0;
  assign misalign_err = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- testbench for instr_fetch.
// Directed vector table for the documented scenarios, a mid-cycle reset
// sequence, then randomized control traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          START_DELAY = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_instruction;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        misalign_err;
  logic [1:0]  dbg_state;

  instr_fetch #(.RESET_PC(RESET_PC), .START_DELAY(START_DELAY)) dut (
    .clk(clk), .rst(rst),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_instruction(rom_instruction),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // ---------------- ROM contents (big-endian) ----------------
  // Bytes 00..0F: 01 02 03 04 11 12 13 14 21 22 23 24 31 32 33 34.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] k;
    if (a < 32'd16) begin
      k = {2'b00, a[3:2], 4'h0};
      return {k + 8'd1, k + 8'd2, k + 8'd3, k + 8'd4};
    end
    return a ^ 32'h5A5A_C3C3;
  endfunction

  assign rom_instruction = rom_en ? rom_word(rom_addr) : 32'h0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 waiting out the start delay, 1 fetching, 2 halted
  int          m_mode;
  int          m_waited;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_idpc;
  logic [31:0] m_instr;
  logic        m_err;

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_pc = RESET_PC;
    m_valid = 0; m_idpc = 0; m_instr = 0; m_err = 0;
  endtask

  // One clock edge of the fetch rules applied to the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = redirect_pc & 32'hFFFF_FFFC;
    case (m_mode)
      0: begin
        if (redirect) begin
          m_pc = tgt;
          if (redirect_pc[1:0] != 2'b00) m_err = 1;
        end
        if (halt) m_mode = 2;
        else if (m_waited + 1 >= START_DELAY) m_mode = 1;
        else m_waited++;
      end
      1: begin
        if (redirect) begin
          m_pc = tgt; m_valid = 0; m_instr = 0;
          if (redirect_pc[1:0] != 2'b00) m_err = 1;
        end else if (halt) begin
          m_mode = 2; m_valid = 0; m_instr = 0;
        end else if (!stall) begin
          m_instr = rom_word(m_pc); m_idpc = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end
      end
      default: begin
        if (redirect) begin
          m_pc = tgt; m_mode = 1;
          if (redirect_pc[1:0] != 2'b00) m_err = 1;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rom_en"},   {31'd0, rom_en},       {31'd0, m_mode == 1});
    check({tag, ".rom_addr"}, rom_addr,              m_pc);
    check({tag, ".id_valid"}, {31'd0, id_valid},     {31'd0, m_valid});
    check({tag, ".id_pc"},    id_pc,                 m_idpc);
    check({tag, ".id_instr"}, id_instr,              m_instr);
    check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, m_err});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rom_en"},   {31'd0, rom_en},       32'd0);
    check({tag, ".rom_addr"}, rom_addr,              RESET_PC);
    check({tag, ".id_valid"}, {31'd0, id_valid},     32'd0);
    check({tag, ".id_pc"},    id_pc,                 32'd0);
    check({tag, ".id_instr"}, id_instr,              32'd0);
    check({tag, ".misalign"}, {31'd0, misalign_err}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st, rd, hl;
    logic [31:0] rpc;
    logic        e_en, e_valid, e_err;
    logic [31:0] e_addr, e_pc, e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic rd, input logic hl,
                              input logic [31:0] rpc, input logic en,
                              input logic v, input logic er, input logic [31:0] ad,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t r;
    r.st = st; r.rd = rd; r.hl = hl; r.rpc = rpc;
    r.e_en = en; r.e_valid = v; r.e_err = er;
    r.e_addr = ad; r.e_pc = pc; r.e_instr = ins;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic rd, input logic hl, input logic [31:0] rpc);
    stall = st; redirect = rd; halt = hl; redirect_pc = rpc;
  endtask

  initial begin
    //        st rd hl rpc            en v  er addr          id_pc         id_instr
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 0, 0, 32'h0,       32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 0, 32'h4,       32'h0,       32'h01020304));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 0, 32'h8,       32'h4,       32'h11121314));
    tbl.push_back(mk(1, 0, 0, 32'h0,       1, 1, 0, 32'h8,       32'h4,       32'h11121314));
    tbl.push_back(mk(1, 0, 0, 32'h0,       1, 1, 0, 32'h8,       32'h4,       32'h11121314));
    tbl.push_back(mk(1, 0, 0, 32'h0,       1, 1, 0, 32'h8,       32'h4,       32'h11121314));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 0, 32'hC,       32'h8,       32'h21222324));
    tbl.push_back(mk(0, 1, 0, 32'hC,       1, 0, 0, 32'hC,       32'h8,       32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 0, 32'h10,      32'hC,       32'h31323334));
    tbl.push_back(mk(1, 1, 0, 32'h6,       1, 0, 1, 32'h4,       32'hC,       32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,       1, 0, 1, 32'h4,       32'hC,       32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 1, 32'h8,       32'h4,       32'h11121314));
    tbl.push_back(mk(0, 1, 0, 32'h0,       1, 0, 1, 32'h0,       32'h4,       32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h0,       0, 0, 1, 32'h0,       32'h4,       32'h0));
    tbl.push_back(mk(0, 0, 1, 32'h0,       0, 0, 1, 32'h0,       32'h4,       32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h0,       0, 0, 1, 32'h0,       32'h4,       32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,       1, 0, 1, 32'h0,       32'h4,       32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 1, 32'h4,       32'h0,       32'h01020304));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFC,1, 0, 1, 32'hFFFFFFFC,32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,       1, 1, 1, 32'h0,       32'hFFFFFFFC, rom_word(32'hFFFFFFFC)));

    // Reset held across an edge, then released between edges.
    @(posedge clk); #1;
    check_reset_vals("rst_held");
    rst = 1'b0;
    #1;
    check_reset_vals("rst_released");

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].rd, tbl[i].hl, tbl[i].rpc);
      @(posedge clk); #1;
      check($sformatf("v%0d.rom_en", i),   {31'd0, rom_en},       {31'd0, tbl[i].e_en});
      check($sformatf("v%0d.rom_addr", i), rom_addr,              tbl[i].e_addr);
      check($sformatf("v%0d.id_valid", i), {31'd0, id_valid},     {31'd0, tbl[i].e_valid});
      check($sformatf("v%0d.id_pc", i),    id_pc,                 tbl[i].e_pc);
      check($sformatf("v%0d.id_instr", i), id_instr,              tbl[i].e_instr);
      check($sformatf("v%0d.misalign", i), {31'd0, misalign_err}, {31'd0, tbl[i].e_err});
    end

    // Mid-cycle async reset: outputs must clear before the next edge.
    drive(0, 0, 0, 32'h0);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    #1 rst = 1'b0;
    model_reset();

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_model("rand_rst");
        #1 rst = 1'b0;
      end
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)}
                                        : 32'($urandom_range(0, 31)));
      model_step();
      @(posedge clk); #1;
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch initiator for the vcpu1 core.
- Owns the program counter and drives address/enable into the big-endian, combinational instruction ROM.
- Captures the returned word into an IF/ID pipeline register for the decoder.
- Handles stall, branch redirect, halt and post-reset startup.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- START_DELAY, 1, idle cycles (rom_en low) after reset release before the first fetch; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_en  output  1  instruction ROM enable.
- rom_addr  output  32  byte address to ROM; always word-aligned (bits [1:0] = 0).
- rom_instruction  input  32  ROM data; valid in the same cycle as rom_addr (combinational ROM); 32'h0 when rom_en low.
- stall  input  1  downstream hold request.
- redirect  input  1  branch/jump taken.
- redirect_pc  input  32  target byte address.
- halt  input  1  stop fetching.
- id_valid  output  1  IF/ID register holds a real instruction.
- id_pc  output  32  address of id_instr.
- id_instr  output  32  fetched instruction; 32'h0 (NOP) when id_valid = 0.
- misalign_err  output  1  sticky flag; set when a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst = 1): state = WAIT, pc = RESET_PC, delay counter = 0.
  - rom_en = 0, rom_addr = RESET_PC.
  - id_valid = 0, id_pc = 0, id_instr = 0, misalign_err = 0.
- rom_addr = pc at all times. rom_en = 1 only in state FETCH.
- State WAIT:
  - Counter increments each cycle.
  - When count = START_DELAY-1, go to FETCH.
  - redirect in WAIT loads pc but does not shorten the delay.
  - halt in WAIT goes to HALTED.
- State FETCH, evaluated each cycle with priority redirect > halt > stall > advance:
  - redirect: pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0; id_instr <= 0; id_pc unchanged. If redirect_pc[1:0] != 0, misalign_err <= 1. Stall is ignored; the instruction in IF/ID is squashed.
  - halt: state <= HALTED; id_valid <= 0; id_instr <= 0; pc unchanged.
  - stall: pc, id_valid, id_pc, id_instr all hold their values.
  - advance: id_instr <= rom_instruction; id_pc <= pc; id_valid <= 1; pc <= pc + 4.
- State HALTED:
  - rom_en = 0; IF/ID holds invalid/NOP.
  - redirect loads the aligned target (same misalign rule) and returns to FETCH. The first fetch from that target happens in the next cycle.
  - halt and stall are ignored in HALTED.
- Latency: a word presented at cycle n appears on id_instr at cycle n+1.
  - After reset release, the first id_valid = 1 occurs START_DELAY+1 cycles after the first clk edge with rst low.
  - Redirect penalty: one bubble cycle.
- PC arithmetic: 32-bit modulo. pc = 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Simultaneous redirect + stall: redirect wins; the stall is not carried over. The next cycle obeys stall as sampled then.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk. No partial IF/ID update survives.
- misalign_err is cleared only by rst.
- No X on any output after reset. id_instr is forced to 0 whenever id_valid = 0.

Test Plan:
- Reset with RESET_PC=0, START_DELAY=1, ROM bytes 00..0F = 01 02 03 04 11 12 13 14 21 22 23 24 31 32 33 34, no stall -> rom_en low for 1 cycle. Then id_instr = 01020304/11121314/21222324 with id_pc = 0/4/8 on consecutive cycles, id_valid = 1.
- Stall held for 3 cycles while id_pc=4 -> id_pc=4, id_instr=11121314 and rom_addr=8 held for 3 cycles. Next cycle: id_pc=8, id_instr=21222324.
- redirect=1, redirect_pc=32'h0C during fetch of 8 -> next cycle id_valid=0, id_instr=0. Following cycle id_pc=0C, id_instr=31323334.
- redirect with stall=1 and redirect_pc=32'h06 -> pc=4, misalign_err=1 and stays 1 through later correct redirects until rst.
- halt=1 -> rom_en=0, id_valid=0 indefinitely. Then redirect_pc=0 -> FETCH resumes, id_pc=0, id_instr=01020304 two cycles later.
- pc preloaded to FFFFFFFC via redirect, advance -> rom_addr becomes 0. Assert rst between edges -> outputs return to reset values before the next clk edge.
